// File: rtl/id_front.sv
// Decode-front stage: owns the IF/ID register, resolves beq/bne/j/jal in ID,
// and raises the fetch redirect and stall controls.
module id_front #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_if,
    input  logic [31:0] PC_if,
    input  logic        IF_flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_MemRead,
    input  logic        ex_RegWrite,
    input  logic [4:0]  ex_wreg,
    input  logic        mem_MemRead,
    input  logic        mem_RegWrite,
    input  logic [4:0]  mem_wreg,
    input  logic [31:0] mem_alu_result,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC4_id,
    output logic        valid_id,
    output logic        Branch,
    output logic        Jump,
    output logic [31:0] JumpAddr,
    output logic        IFWrite,
    output logic        stall_id
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [5:0]  opcode;
    logic        isBeq, isBne, isBranch, isJump;
    logic [31:0] rsVal, rtVal;
    logic        operandsEqual;
    logic        loadUseHazard, branchExHazard, branchMemHazard;
    logic [31:0] branchTarget, jumpTarget;

    // A stall must win over a flush: the stalled instruction is still live.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (!stall_id) begin
            if (IF_flush) begin
                instr_d = NOP_INSTR;
                pc_d    = PC_if;
                valid_d = 1'b0;
            end else begin
                instr_d = Instruction_if;
                pc_d    = PC_if;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign Instruction_id = instr_q;
    assign valid_id       = valid_q;
    assign PC4_id         = pc_q + 32'd4;
    assign rs_addr        = instr_q[25:21];
    assign rt_addr        = instr_q[20:16];

    assign opcode   = instr_q[31:26];
    assign isBeq    = (opcode == OP_BEQ);
    assign isBne    = (opcode == OP_BNE);
    assign isBranch = isBeq || isBne;
    assign isJump   = (opcode == OP_J) || (opcode == OP_JAL);

    // Only a non-load MEM result can be forwarded; WB is covered by the register file.
    assign rsVal = (mem_RegWrite && !mem_MemRead && (mem_wreg != 5'd0) && (mem_wreg == rs_addr))
                   ? mem_alu_result : rs_data;
    assign rtVal = (mem_RegWrite && !mem_MemRead && (mem_wreg != 5'd0) && (mem_wreg == rt_addr))
                   ? mem_alu_result : rt_data;
    assign operandsEqual = (rsVal == rtVal);

    assign loadUseHazard   = !isJump && ex_MemRead && (ex_wreg != 5'd0)
                             && ((ex_wreg == rs_addr) || (ex_wreg == rt_addr));
    assign branchExHazard  = isBranch && ex_RegWrite && (ex_wreg != 5'd0)
                             && ((ex_wreg == rs_addr) || (ex_wreg == rt_addr));
    assign branchMemHazard = isBranch && mem_MemRead && (mem_wreg != 5'd0)
                             && ((mem_wreg == rs_addr) || (mem_wreg == rt_addr));

    assign stall_id = valid_q && (loadUseHazard || branchExHazard || branchMemHazard);
    assign IFWrite  = !stall_id;

    assign Branch = valid_q && !stall_id && ((isBeq && operandsEqual) || (isBne && !operandsEqual));
    assign Jump   = valid_q && isJump;

    assign branchTarget = PC4_id + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jumpTarget   = {PC4_id[31:28], instr_q[25:0], 2'b00};
    assign JumpAddr     = isJump ? jumpTarget : branchTarget;

endmodule

// File: tb/tb_id_front.sv
// Bench for id_front: a directed vector table for the pipeline scenarios,
// then randomized cycles against a behavioural model of the ID stage.
module tb_id_front;

    typedef struct packed {
        bit          reset;
        logic [31:0] instr;
        logic [31:0] pc;
        bit          flush;
        logic [31:0] rsData;
        logic [31:0] rtData;
        bit          exMemRead;
        bit          exRegWrite;
        logic [4:0]  exWreg;
        bit          memMemRead;
        bit          memRegWrite;
        logic [4:0]  memWreg;
        logic [31:0] memAlu;
    } in_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          valid;
        bit          branch;
        bit          jump;
        logic [31:0] jaddr;
        bit          stall;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction_if, PC_if;
    logic        IF_flush;
    logic [31:0] rs_data, rt_data;
    logic        ex_MemRead, ex_RegWrite;
    logic [4:0]  ex_wreg;
    logic        mem_MemRead, mem_RegWrite;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_alu_result;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] Instruction_id, PC4_id, JumpAddr;
    logic        valid_id, Branch, Jump, IFWrite, stall_id;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    id_front dut (
        .clk(clk), .reset(reset),
        .Instruction_if(Instruction_if), .PC_if(PC_if), .IF_flush(IF_flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_wreg(ex_wreg),
        .mem_MemRead(mem_MemRead), .mem_RegWrite(mem_RegWrite), .mem_wreg(mem_wreg),
        .mem_alu_result(mem_alu_result),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .Instruction_id(Instruction_id), .PC4_id(PC4_id), .valid_id(valid_id),
        .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
        .IFWrite(IFWrite), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(bit r, logic [31:0] ins, logic [31:0] pc, bit fl);
        in_t t;
        t = '0;
        t.reset = r;
        t.instr = ins;
        t.pc    = pc;
        t.flush = fl;
        return t;
    endfunction

    function automatic exp_t mkExp(logic [31:0] ins, logic [31:0] pc4, bit v, bit br, bit j,
                                   logic [31:0] ja, bit st);
        exp_t e;
        e.instr = ins; e.pc4 = pc4; e.valid = v; e.branch = br;
        e.jump = j; e.jaddr = ja; e.stall = st;
        return e;
    endfunction

    task automatic addVec(in_t t, exp_t e);
        vec_t v;
        v.in = t;
        v.ex = e;
        vecs.push_back(v);
    endtask

    // Behavioural view of the ID stage: decode fields by arithmetic, apply the hazard rules.
    function automatic logic [31:0] fwdVal(int addr, logic [31:0] rf, in_t x);
        if (x.memRegWrite && !x.memMemRead && int'(x.memWreg) != 0 && int'(x.memWreg) == addr)
            return x.memAlu;
        return rf;
    endfunction

    function automatic exp_t refModel(logic [31:0] ins, logic [31:0] pc, bit v, in_t x);
        exp_t e;
        int op, rs, rt, imm, exW, memW;
        bit isBr, isJ, eq, hz;
        logic [31:0] pc4;
        op   = int'(ins / 32'h0400_0000);
        rs   = int'((ins / 32'h0020_0000) % 32);
        rt   = int'((ins / 32'h0001_0000) % 32);
        imm  = int'(ins % 65536);
        if (imm >= 32768) imm = imm - 65536;
        exW  = int'(x.exWreg);
        memW = int'(x.memWreg);
        isBr = (op == 4) || (op == 5);
        isJ  = (op == 2) || (op == 3);
        eq   = fwdVal(rs, x.rsData, x) == fwdVal(rt, x.rtData, x);
        hz   = 0;
        if (!isJ && x.exMemRead && exW != 0 && (exW == rs || exW == rt)) hz = 1;
        if (isBr && x.exRegWrite && exW != 0 && (exW == rs || exW == rt)) hz = 1;
        if (isBr && x.memMemRead && memW != 0 && (memW == rs || memW == rt)) hz = 1;
        pc4 = pc + 32'd4;
        e.instr  = ins;
        e.pc4    = pc4;
        e.valid  = v;
        e.stall  = v && hz;
        e.branch = v && !e.stall && ((op == 4 && eq) || (op == 5 && !eq));
        e.jump   = v && isJ;
        if (isJ) e.jaddr = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        else     e.jaddr = pc4 + 32'(imm * 4);
        return e;
    endfunction

    task automatic applyStimulus(in_t t);
        reset          = t.reset;
        Instruction_if = t.instr;
        PC_if          = t.pc;
        IF_flush       = t.flush;
        rs_data        = t.rsData;
        rt_data        = t.rtData;
        ex_MemRead     = t.exMemRead;
        ex_RegWrite    = t.exRegWrite;
        ex_wreg        = t.exWreg;
        mem_MemRead    = t.memMemRead;
        mem_RegWrite   = t.memRegWrite;
        mem_wreg       = t.memWreg;
        mem_alu_result = t.memAlu;
    endtask

    task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s %s: got %h, expected %h", name, field, act, expv);
        end
    endtask

    task automatic checkOutput(string name, exp_t e);
        logic [31:0] ins;
        ins = e.instr;
        cmp(name, "Instruction_id", Instruction_id, e.instr);
        cmp(name, "PC4_id", PC4_id, e.pc4);
        cmp(name, "valid_id", 32'(valid_id), 32'(e.valid));
        cmp(name, "Branch", 32'(Branch), 32'(e.branch));
        cmp(name, "Jump", 32'(Jump), 32'(e.jump));
        cmp(name, "JumpAddr", JumpAddr, e.jaddr);
        cmp(name, "stall_id", 32'(stall_id), 32'(e.stall));
        cmp(name, "IFWrite", 32'(IFWrite), 32'(!e.stall));
        cmp(name, "rs_addr", 32'(rs_addr), 32'(ins[25:21]));
        cmp(name, "rt_addr", 32'(rt_addr), 32'(ins[20:16]));
    endtask

    function automatic in_t randIn();
        in_t t;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic [15:0] imm;
        case ($urandom_range(0, 6))
            0: op = 6'h00;
            1: op = 6'h04;
            2: op = 6'h05;
            3: op = 6'h02;
            4: op = 6'h03;
            5: op = 6'h08;
            default: op = 6'h23;
        endcase
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        t = '0;
        t.reset       = ($urandom_range(0, 49) == 0);
        t.instr       = {op, rs, rt, imm};
        t.pc          = $urandom & 32'hFFFF_FFFC;
        t.rsData      = 32'($urandom_range(0, 3));
        t.rtData      = 32'($urandom_range(0, 3));
        t.exMemRead   = ($urandom_range(0, 3) == 0);
        t.exRegWrite  = 1'($urandom_range(0, 1));
        t.exWreg      = 5'($urandom_range(0, 7));
        t.memMemRead  = ($urandom_range(0, 3) == 0);
        t.memRegWrite = 1'($urandom_range(0, 1));
        t.memWreg     = 5'($urandom_range(0, 7));
        t.memAlu      = 32'($urandom_range(0, 3));
        return t;
    endfunction

    initial begin
        in_t t;
        exp_t e;
        logic [31:0] mInstr, mPc;
        bit mValid;
        localparam logic [31:0] A = 32'h2001_0001, B = 32'h2002_0002, C = 32'h2003_0003;
        localparam logic [31:0] X = 32'h2004_0004, D = 32'h2005_0005, E = 32'h2006_0006;
        localparam logic [31:0] F = 32'h2007_0007, G = 32'h2008_0008, H = 32'h2009_0009;
        localparam logic [31:0] BEQ = 32'h1022_0003, BNE = 32'h14C0_FFFF;
        localparam logic [31:0] JMP = 32'h0800_0100, ADD = 32'h0065_2020;

        // Each row: inputs for one cycle and the outputs expected during that cycle.
        t = mk(1, 0, 0, 0);            addVec(t, mkExp(0, 4, 0, 0, 0, 4, 0));
        t = mk(0, A, 0, 0);            addVec(t, mkExp(0, 4, 0, 0, 0, 4, 0));
        t = mk(0, B, 4, 0);            addVec(t, mkExp(A, 4, 1, 0, 0, 8, 0));
        t = mk(0, C, 8, 0);            addVec(t, mkExp(B, 8, 1, 0, 0, 'h10, 0));
        t = mk(0, BEQ, 'h10, 0);       addVec(t, mkExp(C, 'hC, 1, 0, 0, 'h18, 0));
        t = mk(0, X, 'h14, 1); t.rsData = 5; t.rtData = 5;
        addVec(t, mkExp(BEQ, 'h14, 1, 1, 0, 'h20, 0));
        t = mk(0, BEQ, 'h20, 0);       addVec(t, mkExp(0, 'h18, 0, 0, 0, 'h18, 0));
        t = mk(0, D, 'h24, 0); t.rsData = 5; t.rtData = 6;
        addVec(t, mkExp(BEQ, 'h24, 1, 0, 0, 'h30, 0));
        t = mk(0, JMP, 'h40, 0);       addVec(t, mkExp(D, 'h28, 1, 0, 0, 'h3C, 0));
        t = mk(0, E, 'h44, 1);         addVec(t, mkExp(JMP, 'h44, 1, 0, 1, 'h400, 0));
        t = mk(0, ADD, 'h400, 0);      addVec(t, mkExp(0, 'h48, 0, 0, 0, 'h48, 0));
        t = mk(0, F, 'h404, 0); t.exMemRead = 1; t.exWreg = 3;
        addVec(t, mkExp(ADD, 'h404, 1, 0, 0, 'h8484, 1));
        t = mk(0, F, 'h404, 0);        addVec(t, mkExp(ADD, 'h404, 1, 0, 0, 'h8484, 0));
        t = mk(0, ADD, 'h408, 0); t.exMemRead = 1; t.exWreg = 0;
        addVec(t, mkExp(F, 'h408, 1, 0, 0, 'h424, 0));
        t = mk(0, G, 'h40C, 0); t.exMemRead = 1; t.exWreg = 0;
        addVec(t, mkExp(ADD, 'h40C, 1, 0, 0, 'h848C, 0));
        t = mk(0, BNE, 'h80, 0);       addVec(t, mkExp(G, 'h410, 1, 0, 0, 'h430, 0));
        t = mk(0, H, 'h84, 0); t.exRegWrite = 1; t.exWreg = 6;
        addVec(t, mkExp(BNE, 'h84, 1, 0, 0, 'h80, 1));
        t = mk(0, H, 'h84, 1); t.memRegWrite = 1; t.memWreg = 6; t.memAlu = 7;
        addVec(t, mkExp(BNE, 'h84, 1, 1, 0, 'h80, 0));
        t = mk(0, BNE, 'h80, 0);       addVec(t, mkExp(0, 'h88, 0, 0, 0, 'h88, 0));
        t = mk(0, H, 'h84, 0); t.memMemRead = 1; t.memRegWrite = 1; t.memWreg = 6;
        addVec(t, mkExp(BNE, 'h84, 1, 0, 0, 'h80, 1));
        t.reset = 1;                   addVec(t, mkExp(BNE, 'h84, 1, 0, 0, 'h80, 1));
        t = mk(0, A, 0, 0);            addVec(t, mkExp(0, 4, 0, 0, 0, 4, 0));

        applyStimulus(mk(1, 0, 0, 0));
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            #3;
            checkOutput($sformatf("vec%0d", i), vecs[i].ex);
            @(posedge clk);
            #1;
        end

        applyStimulus(mk(1, 0, 0, 0));
        @(posedge clk);
        #1;
        mInstr = 0; mPc = 0; mValid = 0;
        for (int n = 0; n < 3000; n++) begin
            t = randIn();
            e = refModel(mInstr, mPc, mValid, t);
            if ($urandom_range(0, 4) != 0) t.flush = e.branch || e.jump;
            else                           t.flush = 1'($urandom_range(0, 1));
            applyStimulus(t);
            #3;
            checkOutput($sformatf("rnd%0d", n), e);
            if (t.reset) begin
                mInstr = 0; mPc = 0; mValid = 0;
            end else if (!e.stall) begin
                mInstr = t.flush ? 32'd0 : t.instr;
                mPc    = t.pc;
                mValid = !t.flush;
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
